// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I controllers: opcodes, FSM states, mux selects, state decode.
// MC_ILLEGAL_TRAP_EN adds the StTrap state and its decode.
package rv_ctrl_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned STATE_W = 4;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_LW     = 7'b0000011;
    localparam opcode_t OP_SW     = 7'b0100011;
    localparam opcode_t OP_RTYPE  = 7'b0110011;
    localparam opcode_t OP_ITYPE  = 7'b0010011;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_JAL    = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
`ifdef MC_ILLEGAL_TRAP_EN
        StJal      = 4'd10,
        StTrap     = 4'd11
`else
        StJal      = 4'd10
`endif
    } ctrl_state_e;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam ctrl_state_e StLast = StTrap;
`else
    localparam ctrl_state_e StLast = StJal;
`endif

    typedef enum logic [1:0] {AluOpAdd = 2'b00, AluOpSub = 2'b01, AluOpFunct = 2'b10} alu_op_e;
    typedef enum logic [1:0] {ImmI = 2'b00, ImmS = 2'b01, ImmB = 2'b10, ImmJ = 2'b11} imm_src_e;
    typedef enum logic [1:0] {
        ResAluOut = 2'b00, ResData = 2'b01, ResAluResult = 2'b10
    } result_src_e;
    typedef enum logic [1:0] {SrcAPc = 2'b00, SrcAOldPc = 2'b01, SrcARd1 = 2'b10} alu_src_a_e;
    typedef enum logic [1:0] {SrcBRd2 = 2'b00, SrcBImm = 2'b01, SrcBFour = 2'b10} alu_src_b_e;

    // Moore part of the outputs; the pcw_*/irw_* flags say which condition gates each enable.
    typedef struct packed {
        logic        adr_src;
        logic        mem_write;
        logic        reg_write;
        logic        pcw_uncond;
        logic        pcw_on_ready;
        logic        pcw_on_branch;
        logic        irw_on_ready;
        logic        illegal;
        result_src_e result_src;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
    } ctrl_dec_t;

    function automatic ctrl_dec_t state_decode(ctrl_state_e s);
        ctrl_dec_t d;
        d = '0;
        case (s)
            StFetch: begin
                d.alu_src_b    = SrcBFour;
                d.result_src   = ResAluResult;
                d.pcw_on_ready = 1'b1;
                d.irw_on_ready = 1'b1;
            end
            StDecode: begin
                d.alu_src_a = SrcAOldPc;
                d.alu_src_b = SrcBImm;
            end
            StMemAdr: begin
                d.alu_src_a = SrcARd1;
                d.alu_src_b = SrcBImm;
            end
            StMemRead:  d.adr_src = 1'b1;
            StMemWb: begin
                d.result_src = ResData;
                d.reg_write  = 1'b1;
            end
            StMemWrite: begin
                d.adr_src   = 1'b1;
                d.mem_write = 1'b1;
            end
            StExecR: begin
                d.alu_src_a = SrcARd1;
                d.alu_op    = AluOpFunct;
            end
            StExecI: begin
                d.alu_src_a = SrcARd1;
                d.alu_src_b = SrcBImm;
                d.alu_op    = AluOpFunct;
            end
            StAluWb:    d.reg_write = 1'b1;
            StBranch: begin
                d.alu_src_a     = SrcARd1;
                d.alu_op        = AluOpSub;
                d.pcw_on_branch = 1'b1;
            end
            StJal: begin
                d.alu_src_a  = SrcAOldPc;
                d.alu_src_b  = SrcBFour;
                d.pcw_uncond = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            StTrap:     d.illegal = 1'b1;
`endif
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle: master is the controller, slave is the datapath.
// MC_ILLEGAL_TRAP_EN adds illegal_instr.
interface mc_control_fsm_if;
    import rv_ctrl_pkg::*;

    opcode_t    op;
    logic [2:0] funct3;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] ALUOp;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    modport master (
        input  op, funct3, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp
`ifdef MC_ILLEGAL_TRAP_EN
        , output illegal_instr
`endif
    );

    modport slave (
        output op, funct3, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp
`ifdef MC_ILLEGAL_TRAP_EN
        , input illegal_instr
`endif
    );

endinterface

// File: rtl/imm_src_decoder.sv
// Opcode -> immediate format select; purely combinational, shared with the single-cycle core.
module imm_src_decoder
    import rv_ctrl_pkg::*;
(
    input  opcode_t  i_op,
    output imm_src_e o_imm_src
);

    always_comb begin
        o_imm_src = ImmI;
        case (i_op)
            OP_SW:     o_imm_src = ImmS;
            OP_BRANCH: o_imm_src = ImmB;
            OP_JAL:    o_imm_src = ImmJ;
            default:   o_imm_src = ImmI;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main controller: phase sequencing, mux selects, enables and ALUOp.
// MC_ILLEGAL_TRAP_EN: unrecognised opcodes lock the FSM in StTrap with illegal_instr set.
module mc_control_fsm
    import rv_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    mc_control_fsm_if.master   bus
);

    ctrl_state_e r_state;
    ctrl_state_e w_state_next;
    ctrl_dec_t   r_dec;
    ctrl_dec_t   w_dec;
    logic        w_en;
    imm_src_e    w_imm_src;

    always_comb begin
        w_state_next = StFetch;
        case (r_state)
            StFetch:    w_state_next = bus.mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (bus.op)
                    OP_LW, OP_SW: w_state_next = StMemAdr;
                    OP_RTYPE:     w_state_next = StExecR;
                    OP_ITYPE:     w_state_next = StExecI;
                    OP_BRANCH:    w_state_next = StBranch;
                    OP_JAL:       w_state_next = StJal;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      w_state_next = StTrap;
`else
                    default:      w_state_next = StFetch;
`endif
                endcase
            end
            StMemAdr:   w_state_next = (bus.op == OP_LW) ? StMemRead : StMemWrite;
            StMemRead:  w_state_next = bus.mem_ready ? StMemWb : StMemRead;
            StMemWb:    w_state_next = StFetch;
            StMemWrite: w_state_next = bus.mem_ready ? StFetch : StMemWrite;
            StExecR:    w_state_next = StAluWb;
            StExecI:    w_state_next = StAluWb;
            StAluWb:    w_state_next = StFetch;
            StBranch:   w_state_next = StFetch;
            StJal:      w_state_next = StAluWb;
`ifdef MC_ILLEGAL_TRAP_EN
            StTrap:     w_state_next = StTrap;
`endif
            default:    w_state_next = StFetch;
        endcase
    end

    // Decode is registered with the state so outputs never see a decode path from r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
            r_dec   <= state_decode(StFetch);
        end else begin
            r_state <= w_state_next;
            r_dec   <= state_decode(w_state_next);
        end
    end

    // Reset or a corrupted state encoding shows FETCH selects with every enable killed.
    assign w_en  = !reset && (r_state <= StLast);
    assign w_dec = w_en ? r_dec : state_decode(StFetch);

    imm_src_decoder u_imm_src_decoder (
        .i_op      (bus.op),
        .o_imm_src (w_imm_src)
    );

    assign bus.PCWrite   = w_en && (w_dec.pcw_uncond
                                 || (w_dec.pcw_on_ready && bus.mem_ready)
                                 || (w_dec.pcw_on_branch && (bus.Zero ^ bus.funct3[0])));
    assign bus.IRWrite   = w_en && w_dec.irw_on_ready && bus.mem_ready;
    assign bus.MemWrite  = w_en && w_dec.mem_write;
    assign bus.RegWrite  = w_en && w_dec.reg_write;
    assign bus.AdrSrc    = w_dec.adr_src;
    assign bus.ResultSrc = w_dec.result_src;
    assign bus.ALUSrcA   = w_dec.alu_src_a;
    assign bus.ALUSrcB   = w_dec.alu_src_b;
    assign bus.ALUOp     = w_dec.alu_op;
    assign bus.ImmSrc    = w_imm_src;
`ifdef MC_ILLEGAL_TRAP_EN
    assign bus.illegal_instr = w_en && w_dec.illegal;
`endif

endmodule
